audio_mixer: RTL and testbench

- Runtime-programmable N-channel audio mixer. It replaces the fixed compile-time MUL/DIV attenuation constants with per-channel gain registers.
- Time-multiplexed: one multiply-accumulate per clock across all channels, then scale and saturate to the DAC word.
- Sits between the sound sources (PSG, SCC, FM, MEGAROM sound) and the audio DAC/I2S output.

---
 rtl/audio_mixer_pkg.sv | 33 +++
 rtl/audio_mixer_sat.sv | 33 +++
 rtl/audio_mixer.sv | 204 ++++++++++++++++++++
 tb/tb_audio_mixer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// Shared types and constants for the runtime-programmable audio mixer.
//   state_e       : frame sequencer states
//   gain_unity()  : unity gain code for a given number of fraction bits
//   ch_idx_w()    : width of a channel index for n channels
//   GAIN_DEF_*    : gain codes matching the legacy fixed attenuators
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned MAX_CH = 16;

  // Channel index wide enough for the largest supported mixer.
  typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

  // Legacy attenuators: PSG and MEGAROM sound ran at 4/5, FM at unity.
  localparam int unsigned GAIN_DEF_PSG     = 51;
  localparam int unsigned GAIN_DEF_MEGAROM = 51;
  localparam int unsigned GAIN_DEF_FM      = 64;

  function automatic int unsigned gain_unity(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_mixer_sat.sv
// Arithmetic right shift by SHIFT followed by saturation from ACC_W to OUT_W.
// Ports:
//   acc    : signed accumulator value
//   sat_c  : shifted and saturated sample (combinational)
//   clip_c : high when saturation changed the value (combinational)
module audio_mixer_sat
  import audio_mixer_pkg::*;
#(
  parameter int unsigned ACC_W = 29,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [OUT_W-1:0]        sat_c,
  output logic                    clip_c
);

  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-OUT_W:0]    hi;

  // The value fits in OUT_W bits iff every bit from the output sign bit upward agrees.
  always_comb begin
    shifted = acc >>> SHIFT;
    hi      = shifted[ACC_W-1:OUT_W-1];
    clip_c  = !((hi == '0) || (hi == '1));
    if (clip_c) begin
      sat_c = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      sat_c = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/audio_mixer.sv
// N-channel time-multiplexed audio mixer with per-channel programmable gain.
// One multiply-accumulate per clock, then shift/saturate to the DAC word.
// Ports:
//   CLK, RESET        : clock, asynchronous active-high reset
//   CH_IN             : packed signed samples, channel k at [k*IN_W +: IN_W]
//   SAMPLE_STB        : start a mix frame (accepted in IDLE or DONE)
//   GAIN_WE/SEL/DATA  : gain register write port
//   OUT, OUT_VALID    : mixed sample and its one-cycle valid pulse
//   BUSY              : frame in progress (ACCUM/SCALE)
//   CLIP              : last frame saturated, held until the next OUT_VALID
//   OVERRUN           : sticky, SAMPLE_STB seen while BUSY
// Optional (macro AUDIO_MIXER_CLIP_COUNT_EN):
//   CLIP_CNT, CLIP_CNT_CLR : saturating clipped-frame counter and its clear
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_FRAC = 6,
  parameter int unsigned GUARD_W   = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_CH*IN_W-1:0]     CH_IN,
  input  logic                       SAMPLE_STB,
  input  logic                       GAIN_WE,
  input  logic [$clog2(NUM_CH)-1:0]  GAIN_SEL,
  input  logic [GAIN_W-1:0]          GAIN_DATA,
  output logic [OUT_W-1:0]           OUT,
  output logic                       OUT_VALID,
  output logic                       BUSY,
  output logic                       CLIP,
  output logic                       OVERRUN
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  ,
  output logic [15:0]                CLIP_CNT,
  input  logic                       CLIP_CNT_CLR
`endif
);

  localparam int unsigned CH_W   = ch_idx_w(NUM_CH);
  localparam int unsigned ACC_W  = IN_W + GAIN_W + GUARD_W + 1;
  localparam int unsigned PROD_W = IN_W + GAIN_W + 1;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [GAIN_W-1:0]        gain_q [NUM_CH];
  logic [GAIN_W-1:0]        gain_d [NUM_CH];
  logic [GAIN_W-1:0]        gain_sh_q [NUM_CH];
  logic [GAIN_W-1:0]        gain_sh_d [NUM_CH];
  logic signed [IN_W-1:0]   smp_sh_q [NUM_CH];
  logic signed [IN_W-1:0]   smp_sh_d [NUM_CH];
  logic signed [IN_W-1:0]   smp_in_c [NUM_CH];
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     clip_q, clip_d;
  logic                     overrun_q, overrun_d;
  logic signed [PROD_W-1:0] prod_c;
  logic [OUT_W-1:0]         sat_c;
  logic                     clip_c;

  // Unpack the flat sample bus.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      smp_in_c[k] = CH_IN[k*IN_W +: IN_W];
    end
  end

  // Signed sample times unsigned gain: the gain gets a zero sign bit.
  always_comb begin
    prod_c = PROD_W'(smp_sh_q[idx_q]) * PROD_W'($signed({1'b0, gain_sh_q[idx_q]}));
  end

  audio_mixer_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (GAIN_FRAC)
  ) u_sat (
    .acc    (acc_q),
    .sat_c  (sat_c),
    .clip_c (clip_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    gain_d      = gain_q;
    gain_sh_d   = gain_sh_q;
    smp_sh_d    = smp_sh_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    clip_d      = clip_q;
    overrun_d   = overrun_q;

    if (GAIN_WE && (32'(GAIN_SEL) < NUM_CH)) begin
      gain_d[GAIN_SEL] = GAIN_DATA;
    end

    if (SAMPLE_STB && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // Snapshot takes gain_q, so a write on the same edge lands next frame.
        if (SAMPLE_STB) begin
          smp_sh_d  = smp_in_c;
          gain_sh_d = gain_q;
          acc_d     = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(prod_c);
        if (idx_q == CH_W'(NUM_CH - 1)) begin
          state_d = S_SCALE;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      S_SCALE: begin
        out_d       = sat_c;
        clip_d      = clip_c;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        gain_q[k]    <= GAIN_W'(gain_unity(GAIN_FRAC));
        gain_sh_q[k] <= '0;
        smp_sh_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
      gain_q      <= gain_d;
      gain_sh_q   <= gain_sh_d;
      smp_sh_q    <= smp_sh_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;
  assign CLIP      = clip_q;
  assign OVERRUN   = overrun_q;

`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  // Counts on the edge that raises OUT_VALID; clear wins over increment.
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (CLIP_CNT_CLR) begin
      clip_cnt_d = '0;
    end else if ((state_q == S_SCALE) && clip_c && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign CLIP_CNT = clip_cnt_q;
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer (NUM_CH=6, 16-bit samples, 8.6 gains).
module tb_audio_mixer;

  localparam int unsigned NCH = 6;

  logic              CLK;
  logic              RESET;
  logic [NCH*16-1:0] CH_IN;
  logic              SAMPLE_STB;
  logic              GAIN_WE;
  logic [2:0]        GAIN_SEL;
  logic [7:0]        GAIN_DATA;
  logic [15:0]       OUT;
  logic              OUT_VALID;
  logic              BUSY;
  logic              CLIP;
  logic              OVERRUN;
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  logic [15:0]       CLIP_CNT;
  logic              CLIP_CNT_CLR;
`endif

  audio_mixer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CH_IN        (CH_IN),
    .SAMPLE_STB   (SAMPLE_STB),
    .GAIN_WE      (GAIN_WE),
    .GAIN_SEL     (GAIN_SEL),
    .GAIN_DATA    (GAIN_DATA),
    .OUT          (OUT),
    .OUT_VALID    (OUT_VALID),
    .BUSY         (BUSY),
    .CLIP         (CLIP),
    .OVERRUN      (OVERRUN)
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    ,
    .CLIP_CNT     (CLIP_CNT),
    .CLIP_CNT_CLR (CLIP_CNT_CLR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q [$];

  typedef struct {
    string        name;
    logic [95:0]  ch;
    logic [47:0]  g;
    logic [15:0]  exp_out;
    logic         exp_clip;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact sum of products, floor shift by 6, clamp to 16 bits.
  function automatic logic [16:0] model(input logic [95:0] ch, input logic [47:0] g);
    longint acc;
    logic [15:0] s;
    logic [7:0]  gg;
    acc = 0;
    for (int k = 0; k < NCH; k++) begin
      s  = ch[k*16 +: 16];
      gg = g[k*8 +: 8];
      acc += longint'($signed(s)) * longint'(gg);
    end
    acc = acc >>> 6;
    if (acc > 32767)  return {1'b1, 16'h7FFF};
    if (acc < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(acc)};
  endfunction

  // Scoreboard: every OUT_VALID must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (!RESET && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(OUT_VALID), 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("out", 32'(OUT), 32'(e[15:0]));
        chk("clip", 32'(CLIP), 32'(e[16]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_gains(input logic [47:0] g);
    for (int k = 0; k < NCH; k++) begin
      @(posedge CLK); #1;
      GAIN_WE   = 1'b1;
      GAIN_SEL  = 3'(k);
      GAIN_DATA = g[k*8 +: 8];
    end
    @(posedge CLK); #1;
    GAIN_WE = 1'b0;
  endtask

  task automatic set_one_gain(input int ch, input logic [7:0] v);
    @(posedge CLK); #1;
    GAIN_WE   = 1'b1;
    GAIN_SEL  = 3'(ch);
    GAIN_DATA = v;
    @(posedge CLK); #1;
    GAIN_WE = 1'b0;
  endtask

  // Starts a frame from the current #1-after-edge point and waits for its output.
  task automatic run_frame(input logic [95:0] ch, input logic [15:0] eo, input logic ec);
    int lat;
    CH_IN = ch;
    exp_q.push_back({ec, eo});
    SAMPLE_STB = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_STB = 1'b0;
    GAIN_WE    = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (k == 1) chk("busy_after_stb", 32'(BUSY), 32'd1);
      if (OUT_VALID) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(NCH + 2));
    chk("busy_in_done", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int vcnt;
    logic [95:0] rch;
    logic [47:0] rg;
    logic [16:0] re;

    vecs[0] = '{"unity_mix",   {6{16'h1000}}, {6{8'd64}}, 16'h6000, 1'b0};
    vecs[1] = '{"half_gain",   {{5{16'h1234}}, 16'h2000}, {{5{8'd0}}, 8'd32}, 16'h1000, 1'b0};
    vecs[2] = '{"mute",        {{5{16'h1234}}, 16'h2000}, {6{8'd0}}, 16'h0000, 1'b0};
    vecs[3] = '{"pos_clip",    {6{16'h7FFF}}, {6{8'd64}}, 16'h7FFF, 1'b1};
    vecs[4] = '{"neg_clip",    {6{16'h8000}}, {6{8'd64}}, 16'h8000, 1'b1};
    vecs[5] = '{"signed_sum",  {16'hFDA8, 16'h01F4, 16'hFE70, 16'h012C, 16'hFF38, 16'h0064},
                {6{8'd64}}, 16'hFED4, 1'b0};
    vecs[6] = '{"floor_shift", {{5{16'h7FFF}}, 16'hFFFF}, {{5{8'd0}}, 8'd51}, 16'hFFFF, 1'b0};
    vecs[7] = '{"psg_gain",    {6{16'h0100}}, {6{8'd51}}, 16'h04C8, 1'b0};
    vecs[8] = '{"max_gain",    {{5{16'h7FFF}}, 16'h2000}, {{5{8'd0}}, 8'd255}, 16'h7F80, 1'b0};

    RESET = 1'b1; CH_IN = '0; SAMPLE_STB = 1'b0;
    GAIN_WE = 1'b0; GAIN_SEL = '0; GAIN_DATA = '0;
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    CLIP_CNT_CLR = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    @(negedge CLK);
    chk("rst_out", 32'(OUT), 32'd0);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_clip", 32'(CLIP), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    @(posedge CLK); #1;

    // First frame relies on reset gains being unity.
    run_frame({6{16'h1000}}, 16'h6000, 1'b0);

    foreach (vecs[i]) begin
      set_gains(vecs[i].g);
      run_frame(vecs[i].ch, vecs[i].exp_out, vecs[i].exp_clip);
    end

    for (int i = 0; i < 4; i++) begin
      rch = {$urandom, $urandom, $urandom};
      rg  = 48'({$urandom, $urandom});
      re  = model(rch, rg);
      set_gains(rg);
      run_frame(rch, re[15:0], re[16]);
    end

    // Out-of-range gain selects must be ignored.
    set_gains({6{8'd64}});
    set_one_gain(6, 8'd0);
    set_one_gain(7, 8'd0);
    run_frame({6{16'h1000}}, 16'h6000, 1'b0);

    // Overrun: second strobe 3 edges in is dropped; gain write mid-frame waits.
    CH_IN = {6{16'h1000}};
    exp_q.push_back({1'b0, 16'h6000});
    SAMPLE_STB = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_STB = 1'b0;
    @(posedge CLK); #1;
    GAIN_WE = 1'b1; GAIN_SEL = 3'd0; GAIN_DATA = 8'd0;
    @(posedge CLK); #1;
    GAIN_WE = 1'b0;
    SAMPLE_STB = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_STB = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (OUT_VALID) vcnt++;
    end
    chk("overrun_one_valid", 32'(vcnt), 32'd1);
    chk("overrun_flag", 32'(OVERRUN), 32'd1);
    @(posedge CLK); #1;

    // Gain write coinciding with the strobe: snapshot keeps old gain[1].
    GAIN_WE = 1'b1; GAIN_SEL = 3'd1; GAIN_DATA = 8'd0;
    run_frame({6{16'h1000}}, 16'h5000, 1'b0);
    run_frame({6{16'h1000}}, 16'h4000, 1'b0);

    // Leave CLIP and OUT nonzero, then reset in the middle of ACCUM.
    set_gains({6{8'd64}});
    run_frame({6{16'h7FFF}}, 16'h7FFF, 1'b1);
    set_one_gain(0, 8'd10);
    CH_IN = {6{16'h1000}};
    SAMPLE_STB = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_STB = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_out", 32'(OUT), 32'd0);
    chk("midrst_clip", 32'(CLIP), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_overrun", 32'(OVERRUN), 32'd0);
    vcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (OUT_VALID) vcnt++;
    end
    chk("midrst_no_valid", 32'(vcnt), 32'd0);
    @(posedge CLK); #1;
    run_frame({6{16'h1000}}, 16'h6000, 1'b0);

`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    chk("cnt_after_reset", 32'(CLIP_CNT), 32'd0);
    for (int i = 0; i < 3; i++) run_frame({6{16'h8000}}, 16'h8000, 1'b1);
    chk("cnt_three", 32'(CLIP_CNT), 32'd3);
    CLIP_CNT_CLR = 1'b1;
    run_frame({6{16'h7FFF}}, 16'h7FFF, 1'b1);
    CLIP_CNT_CLR = 1'b0;
    @(negedge CLK);
    chk("cnt_clr_wins", 32'(CLIP_CNT), 32'd0);
    @(posedge CLK); #1;
`endif

    repeat (4) @(posedge CLK);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
